lockout_scheduler: RTL and testbench

- Sequences the shared interval timer to enforce escalating lockouts after repeated wrong code entries.
- Sits between the code-compare logic and the interval timer.
- Counts consecutive failures. On reaching the limit, it blocks entry and chains 2^level timer intervals, where level is the lockout level. Each completed lockout raises the level.
- A correct entry clears all history.

---
 rtl/lockout_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_lockout_scheduler.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lockout_scheduler.sv
// ---------------------------------------------------------------------------
// lockout_scheduler
//   Counts consecutive wrong code entries. On reaching MAX_ATTEMPTS it locks
//   entry and chains 2^level intervals on the shared interval timer, one
//   start per done. Each completed lockout raises the level, which saturates
//   at MAX_LEVEL. A correct entry accepted while unlocked clears all history.
//
// Ports
//   clk           system clock, all state on rising edge
//   rst           asynchronous active-high reset
//   attempt_valid one-cycle pulse: a code entry has been compared
//   attempt_ok    compare result, qualified by attempt_valid
//   timer_done    done pulse from the interval timer
//   timer_start   one-cycle start pulse to the interval timer
//   locked        high for the whole lockout
//   unlock_ok     one-cycle pulse: correct code accepted
//   attempt_rej   one-cycle pulse: attempt arrived while locked (discarded)
//   lockout_done  one-cycle pulse: lockout finished
//   fail_count    current consecutive-failure count
//   level         current lockout level (0..MAX_LEVEL)
// ---------------------------------------------------------------------------
module lockout_scheduler #(
  parameter int unsigned MAX_ATTEMPTS = 3,
  parameter int unsigned MAX_LEVEL    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       attempt_valid,
  input  logic       attempt_ok,
  input  logic       timer_done,
  output logic       timer_start,
  output logic       locked,
  output logic       unlock_ok,
  output logic       attempt_rej,
  output logic       lockout_done,
  output logic [3:0] fail_count,
  output logic [1:0] level
);

  localparam int unsigned FAIL_W  = 4;
  localparam int unsigned LEVEL_W = 2;
  localparam int unsigned INT_W   = MAX_LEVEL + 1;
  localparam int unsigned CMP_W   = FAIL_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t               state_q, state_d;

  logic [FAIL_W-1:0]    fail_count_q, fail_count_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic [INT_W-1:0]     intervals_left_q, intervals_left_d;
  logic                 timer_start_q, timer_start_d;
  logic                 locked_q, locked_d;
  logic                 unlock_ok_q, unlock_ok_d;
  logic                 attempt_rej_q, attempt_rej_d;
  logic                 lockout_done_q, lockout_done_d;

  logic                 wrong_attempt_c;
  logic                 lockout_trigger_c;
  logic                 final_done_c;
  logic                 level_at_max_c;

  // Decode of the events that steer both the FSM and the datapath
  always_comb begin
    wrong_attempt_c   = attempt_valid && !attempt_ok;
    lockout_trigger_c = (state_q == ST_IDLE) && wrong_attempt_c &&
                        ((CMP_W'(fail_count_q) + CMP_W'(1)) >= CMP_W'(MAX_ATTEMPTS));
    // Last interval of the chain completes on this done
    final_done_c      = (state_q == ST_WAIT) && timer_done &&
                        (intervals_left_q == INT_W'(1));
    level_at_max_c    = (32'(level_q) >= MAX_LEVEL);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (lockout_trigger_c) begin
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        // Start is issued during this cycle; any done seen here is stale
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (timer_done) begin
          state_d = final_done_c ? ST_IDLE : ST_ARM;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output / datapath next values; outputs are registered from these
  always_comb begin
    fail_count_d     = fail_count_q;
    level_d          = level_q;
    intervals_left_d = intervals_left_q;
    unlock_ok_d      = 1'b0;
    attempt_rej_d    = 1'b0;
    lockout_done_d   = 1'b0;
    // Start and locked follow the state being entered so they line up with it
    timer_start_d    = (state_d == ST_ARM);
    locked_d         = (state_d != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (attempt_valid) begin
          if (attempt_ok) begin
            unlock_ok_d  = 1'b1;
            fail_count_d = '0;
            level_d      = '0;
          end else if (lockout_trigger_c) begin
            fail_count_d     = '0;
            intervals_left_d = INT_W'(1) << level_q;
          end else begin
            fail_count_d = fail_count_q + FAIL_W'(1);
          end
        end
      end
      ST_ARM: begin
        attempt_rej_d = attempt_valid;
      end
      ST_WAIT: begin
        attempt_rej_d = attempt_valid;
        if (timer_done) begin
          intervals_left_d = intervals_left_q - INT_W'(1);
          if (final_done_c) begin
            lockout_done_d = 1'b1;
            level_d        = level_at_max_c ? level_q : level_q + LEVEL_W'(1);
          end
        end
      end
      default: begin
        attempt_rej_d = attempt_valid;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_count_q     <= '0;
      level_q          <= '0;
      intervals_left_q <= '0;
      timer_start_q    <= 1'b0;
      locked_q         <= 1'b0;
      unlock_ok_q      <= 1'b0;
      attempt_rej_q    <= 1'b0;
      lockout_done_q   <= 1'b0;
    end else begin
      fail_count_q     <= fail_count_d;
      level_q          <= level_d;
      intervals_left_q <= intervals_left_d;
      timer_start_q    <= timer_start_d;
      locked_q         <= locked_d;
      unlock_ok_q      <= unlock_ok_d;
      attempt_rej_q    <= attempt_rej_d;
      lockout_done_q   <= lockout_done_d;
    end
  end

  assign timer_start  = timer_start_q;
  assign locked       = locked_q;
  assign unlock_ok    = unlock_ok_q;
  assign attempt_rej  = attempt_rej_q;
  assign lockout_done = lockout_done_q;
  assign fail_count   = fail_count_q;
  assign level        = level_q;

endmodule

// File: tb/tb_lockout_scheduler.sv
// ---------------------------------------------------------------------------
// tb_lockout_scheduler
//   Directed scenarios plus a randomized run checked against a behavioural
//   model of the lockout rules (failure count, interval budget, level).
// ---------------------------------------------------------------------------
module tb_lockout_scheduler;

  localparam int MAX_ATTEMPTS = 3;
  localparam int MAX_LEVEL    = 3;

  logic       clk;
  logic       rst;
  logic       attempt_valid;
  logic       attempt_ok;
  logic       timer_done;
  logic       timer_start;
  logic       locked;
  logic       unlock_ok;
  logic       attempt_rej;
  logic       lockout_done;
  logic [3:0] fail_count;
  logic [1:0] level;

  int n_cmp;
  int n_fail;

  // Behavioural model state
  int m_fails;
  int m_lvl;
  int m_rem;
  bit m_locked;
  bit m_start;
  bit e_unlock;
  bit e_rej;
  bit e_done;

  lockout_scheduler #(
    .MAX_ATTEMPTS(MAX_ATTEMPTS),
    .MAX_LEVEL   (MAX_LEVEL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .attempt_valid(attempt_valid),
    .attempt_ok   (attempt_ok),
    .timer_done   (timer_done),
    .timer_start  (timer_start),
    .locked       (locked),
    .unlock_ok    (unlock_ok),
    .attempt_rej  (attempt_rej),
    .lockout_done (lockout_done),
    .fail_count   (fail_count),
    .level        (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_fails  = 0;
    m_lvl    = 0;
    m_rem    = 0;
    m_locked = 0;
    m_start  = 0;
    e_unlock = 0;
    e_rej    = 0;
    e_done   = 0;
  endfunction

  // One clock of the lockout rules; m_start is "a start is being issued now"
  function automatic void model_step(input bit av, input bit ok, input bit td);
    bit new_start;
    new_start = 0;
    e_unlock  = 0;
    e_rej     = 0;
    e_done    = 0;
    if (!m_locked) begin
      if (av) begin
        if (ok) begin
          e_unlock = 1;
          m_fails  = 0;
          m_lvl    = 0;
        end else if (m_fails + 1 >= MAX_ATTEMPTS) begin
          m_fails   = 0;
          m_rem     = 2 ** m_lvl;
          m_locked  = 1;
          new_start = 1;
        end else begin
          m_fails++;
        end
      end
    end else begin
      e_rej = av;
      if (!m_start && td) begin
        m_rem--;
        if (m_rem == 0) begin
          m_locked = 0;
          e_done   = 1;
          if (m_lvl < MAX_LEVEL) m_lvl++;
        end else begin
          new_start = 1;
        end
      end
    end
    m_start = new_start;
  endfunction

  // Drive one cycle of inputs, sample after the edge, advance the model
  task automatic tick(input logic av, input logic ok, input logic td);
    @(negedge clk);
    attempt_valid = av;
    attempt_ok    = ok;
    timer_done    = td;
    @(posedge clk);
    #1;
    model_step(av, ok, td);
    attempt_valid = 1'b0;
    attempt_ok    = 1'b0;
    timer_done    = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    attempt_valid = 1'b0;
    attempt_ok    = 1'b0;
    timer_done    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({timer_start, locked, unlock_ok, attempt_rej, lockout_done} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_pulses: got %b expected 00000",
               {timer_start, locked, unlock_ok, attempt_rej, lockout_done});
    end
    n_cmp++;
    if (fail_count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_fail_count: got %0d expected 0", fail_count);
    end
    n_cmp++;
    if (level !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_level: got %0d expected 0", level);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_unlock();
    tick(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if ({unlock_ok, locked, fail_count, level} !== {1'b1, 1'b0, 4'd0, 2'd0}) begin
      n_fail++;
      $display("FAIL unlock: got ok=%b lk=%b fc=%0d lv=%0d expected ok=1 lk=0 fc=0 lv=0",
               unlock_ok, locked, fail_count, level);
    end
    tick(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (unlock_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL unlock_pulse_width: got %b expected 0", unlock_ok);
    end
  endtask

  task automatic test_lockout_basic();
    repeat (2) tick(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (fail_count !== 4'd2 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL two_wrong: got fc=%0d lk=%b expected fc=2 lk=0", fail_count, locked);
    end
    tick(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if ({locked, fail_count, timer_start} !== {1'b1, 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL third_wrong: got lk=%b fc=%0d ts=%b expected lk=1 fc=0 ts=1",
               locked, fail_count, timer_start);
    end
    repeat (3) begin
      tick(1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (timer_start !== 1'b0 || locked !== 1'b1) begin
        n_fail++;
        $display("FAIL single_start: got ts=%b lk=%b expected ts=0 lk=1", timer_start, locked);
      end
    end
    tick(1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({lockout_done, locked, level, timer_start} !== {1'b1, 1'b0, 2'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL level0_done: got dn=%b lk=%b lv=%0d ts=%b expected dn=1 lk=0 lv=1 ts=0",
               lockout_done, locked, level, timer_start);
    end
    tick(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (lockout_done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse_width: got %b expected 0", lockout_done);
    end
  endtask

  // Lock at level lvl and act as the timer: done two idle cycles after each start
  task automatic test_lockout_chain(input int lvl);
    int n_int;
    int starts;
    int exp_lvl;
    n_int   = 2 ** lvl;
    exp_lvl = (lvl < MAX_LEVEL) ? lvl + 1 : MAX_LEVEL;
    starts  = 0;
    n_cmp++;
    if (int'(level) !== lvl) begin
      n_fail++;
      $display("FAIL chain_pre_level: got %0d expected %0d", level, lvl);
    end
    repeat (MAX_ATTEMPTS) tick(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (timer_start !== 1'b1 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL chain_first_start: got ts=%b lk=%b expected ts=1 lk=1", timer_start, locked);
    end
    if (timer_start === 1'b1) starts++;
    for (int i = 1; i <= n_int; i++) begin
      repeat (2) begin
        tick(1'b0, 1'b0, 1'b0);
        if (timer_start === 1'b1) starts++;
        n_cmp++;
        if (locked !== 1'b1) begin
          n_fail++;
          $display("FAIL chain_locked_hold: got %b expected 1 (interval %0d)", locked, i);
        end
      end
      tick(1'b0, 1'b0, 1'b1);
      if (timer_start === 1'b1) starts++;
      n_cmp++;
      if (i < n_int) begin
        if ({timer_start, locked, lockout_done} !== 3'b110) begin
          n_fail++;
          $display("FAIL chain_restart: got ts=%b lk=%b dn=%b expected 1 1 0 (interval %0d)",
                   timer_start, locked, lockout_done, i);
        end
      end else begin
        if ({timer_start, locked, lockout_done} !== 3'b001) begin
          n_fail++;
          $display("FAIL chain_finish: got ts=%b lk=%b dn=%b expected 0 0 1",
                   timer_start, locked, lockout_done);
        end
      end
    end
    n_cmp++;
    if (starts !== n_int) begin
      n_fail++;
      $display("FAIL chain_start_count: got %0d expected %0d", starts, n_int);
    end
    n_cmp++;
    if (int'(level) !== exp_lvl) begin
      n_fail++;
      $display("FAIL chain_post_level: got %0d expected %0d", level, exp_lvl);
    end
  endtask

  task automatic test_unlock_clears_level();
    tick(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (unlock_ok !== 1'b1 || level !== 2'd0) begin
      n_fail++;
      $display("FAIL sat_unlock: got ok=%b lv=%0d expected ok=1 lv=0", unlock_ok, level);
    end
  endtask

  task automatic test_reject_in_wait();
    repeat (MAX_ATTEMPTS) tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if ({attempt_rej, unlock_ok, locked, level, fail_count} !== {1'b1, 1'b0, 1'b1, 2'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL reject_wait: got rj=%b ok=%b lk=%b lv=%0d fc=%0d expected 1 0 1 0 0",
               attempt_rej, unlock_ok, locked, level, fail_count);
    end
    // Wrong attempt on the same cycle as the final done is still rejected
    tick(1'b1, 1'b0, 1'b1);
    n_cmp++;
    if ({attempt_rej, lockout_done, locked, level, fail_count} !== {1'b1, 1'b1, 1'b0, 2'd1, 4'd0}) begin
      n_fail++;
      $display("FAIL reject_final: got rj=%b dn=%b lk=%b lv=%0d fc=%0d expected 1 1 0 1 0",
               attempt_rej, lockout_done, locked, level, fail_count);
    end
    tick(1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({timer_start, locked, unlock_ok, attempt_rej, lockout_done, fail_count, level} !==
        {5'b0, 4'd0, 2'd1}) begin
      n_fail++;
      $display("FAIL stray_done: got ts=%b lk=%b ok=%b rj=%b dn=%b fc=%0d lv=%0d expected 0 0 0 0 0 0 1",
               timer_start, locked, unlock_ok, attempt_rej, lockout_done, fail_count, level);
    end
  endtask

  task automatic test_mid_reset();
    repeat (MAX_ATTEMPTS) tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (locked !== 1'b1 || level !== 2'd1) begin
      n_fail++;
      $display("FAIL mid_reset_setup: got lk=%b lv=%0d expected lk=1 lv=1", locked, level);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({locked, level, fail_count, timer_start} !== {1'b0, 2'd0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset_async: got lk=%b lv=%0d fc=%0d ts=%b expected 0 0 0 0",
               locked, level, fail_count, timer_start);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (5) begin
      tick(1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (timer_start !== 1'b0 || locked !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_quiet: got ts=%b lk=%b expected 0 0", timer_start, locked);
      end
    end
  endtask

  task automatic test_random();
    logic [10:0] got;
    logic [10:0] exp;
    logic        av;
    logic        ok;
    logic        td;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      av = ($urandom_range(2) == 0);
      ok = ($urandom_range(4) == 0);
      td = ($urandom_range(3) == 0);
      tick(av, ok, td);
      got = {timer_start, locked, unlock_ok, attempt_rej, lockout_done, fail_count, level};
      exp = {m_start, m_locked, e_unlock, e_rej, e_done, 4'(m_fails), 2'(m_lvl)};
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random_cycle %0d: got %b expected %b (ts lk ok rj dn fc lv)", c, got, exp);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    model_reset();
    test_reset();
    test_unlock();
    test_lockout_basic();
    test_lockout_chain(1);
    test_lockout_chain(2);
    test_lockout_chain(3);
    test_lockout_chain(3);
    test_unlock_clears_level();
    test_reject_in_wait();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
